// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides and registered result/flags.
// Optional iterative SLL/SRL (codes 110/111) is built only when ALU_SERIAL_SHIFT_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic             add_ovf;
    logic             sub_ovf;

    logic [WIDTH-1:0] exec_res;
    logic             exec_c;
    logic             exec_v;
    logic             exec_ill;
    logic             exec_shift;

    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;
    logic             load_ill;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);

    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Negative = neg_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Illegal  = ill_q;

    // Subtraction as A + ~B + 1 so the top bit is the "no borrow" carry.
    assign sum_w   = {1'b0, A} + {1'b0, B};
    assign diff_w  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) & (sum_w[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) & (diff_w[WIDTH-1] != A[WIDTH-1]);

`ifdef ALU_SERIAL_SHIFT_EN
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shift_step;
    logic             shift_last;

    assign shamt      = B[SW-1:0];
    assign shift_step = dir_q ? (shift_q >> 1) : (shift_q << 1);
    assign shift_last = (state_q == BUSY) && (cnt_q == SW'(1));
`endif

    // One-cycle operations; reserved codes fall through to the default arm.
    always_comb begin
        exec_res   = '0;
        exec_c     = 1'b0;
        exec_v     = 1'b0;
        exec_ill   = 1'b0;
        exec_shift = 1'b0;
        case (ALUControl)
            3'b000: begin
                exec_res = sum_w[WIDTH-1:0];
                exec_c   = sum_w[WIDTH];
                exec_v   = add_ovf;
            end
            3'b001: begin
                exec_res = diff_w[WIDTH-1:0];
                exec_c   = diff_w[WIDTH];
                exec_v   = sub_ovf;
            end
            3'b010: exec_res = A & B;
            3'b011: exec_res = A | B;
            3'b101: exec_res = {{(WIDTH-1){1'b0}}, diff_w[WIDTH-1] ^ sub_ovf};
`ifdef ALU_SERIAL_SHIFT_EN
            3'b110, 3'b111: begin
                if (shamt == '0) begin
                    exec_res = A;
                end else begin
                    exec_shift = 1'b1;
                end
            end
`endif
            default: exec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        load     = 1'b0;
        load_res = exec_res;
        load_c   = exec_c;
        load_v   = exec_v;
        load_ill = exec_ill;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (exec_shift) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_SERIAL_SHIFT_EN
            BUSY: begin
                if (shift_last) begin
                    state_d  = DONE;
                    load     = 1'b1;
                    load_res = shift_step;
                    load_c   = 1'b0;
                    load_v   = 1'b0;
                    load_ill = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Zero/Negative always derive from the value actually registered.
        if (load) begin
            result_d = load_res;
            zero_d   = (load_res == '0);
            neg_d    = load_res[WIDTH-1];
            carry_d  = load_c;
            ovf_d    = load_v;
            ill_d    = load_ill;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end

`ifdef ALU_SERIAL_SHIFT_EN
    // Working copy of the operand shifts one place per BUSY cycle.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (accept && exec_shift) begin
            shift_d = A;
            cnt_d   = shamt;
            dir_d   = ALUControl[0];
        end else if (state_q == BUSY) begin
            shift_d = shift_step;
            cnt_d   = cnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
`endif

endmodule
